line_clear_engine: RTL and testbench
====================================

// Module: line_clear_engine
// PURPOSE
//  Consumes the per-row full-line flags and the board image used to compute them. Removes every full row and
//  collapses the rows above downward, one row per cycle. Writes the compacted board back to board memory.
//  Sits between the full-line checker and the board-memory register in the game datapath.
//  The game FSM pulses start once the checker's registered fullLine output has settled.
// PARAMETERS
//  ROWS   20  board height in rows; row 0 is the top row
//  COLS   10  board width; row r occupies bits r*COLS .. r*COLS+COLS-1
//  CNT_W  16  width of the lifetime cleared-line counter
// PORTS
//  clk            in   1          system clock
//  rst_n          in   1          synchronous, active-low reset
//  start          in   1          request a clear pass; ignored unless idle
//  board_in       in   [0:ROWS*COLS-1]  board image, MSB-first like board memory
//  full_lines     in   [0:ROWS-1] per-row full flags for board_in
//  board_out      out  [0:ROWS*COLS-1]  compacted board; valid while board_we=1
//  board_we       out  1          one-cycle write strobe to board memory
//  done           out  1          one-cycle pass-complete pulse, coincident with board_we
//  busy           out  1          high from the cycle after start is accepted until done falls
//  lines_cleared  out  5          rows removed in the last pass; held until the next pass commits
//  total_lines    out  CNT_W      lifetime cleared rows; saturates at all-ones
//  score          out  20         present only with LINE_CLEAR_SCORE_EN
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state=IDLE; board_we, done, busy = 0; lines_cleared = 0; total_lines = 0; score = 0; board_out = 0.
//   - A reset mid-pass abandons the pass with no board_we.
//  FSM states: IDLE, CLEAR, COMMIT. All outputs are registered.
//   - IDLE: on start=1, snapshot board_in into brd and full_lines into mask; pass counter k=0; go to CLEAR.
//   - CLEAR, mask!=0:
//     - r = highest-index set bit of mask, i.e. the bottom-most full row.
//     - Rows 1..r of brd take rows 0..r-1; row 0 becomes all zeros; rows >r are unchanged.
//     - mask is shifted the same way, with bit r removed and bit 0 cleared. k increments.
//     - Stay in CLEAR.
//   - CLEAR, mask==0: board_out<=brd; lines_cleared<=k; update total_lines (and score); go to COMMIT.
//   - COMMIT: board_we=1 and done=1 for exactly this cycle; return to IDLE.
//  Latency: start sampled at edge E with k full rows gives board_we high in the cycle starting at edge E+k+1.
//   A zero-line pass still commits, at E+1, with board_out equal to the snapshot.
//  start while busy or in COMMIT: ignored, no queuing.
//  Inputs are sampled only at start; later changes to board_in/full_lines do not affect the pass.
//  A pass with all ROWS full gives an all-zero board and lines_cleared=ROWS.
//  total_lines += k saturating; a wrap is a bug.
// CONFIGURATION
//  LINE_CLEAR_SCORE_EN defined:
//   - score port and register exist.
//   - At the CLEAR->COMMIT transition, score += table[k]: k 0/1/2/3/>=4 -> 0/40/100/300/1200.
//   - score saturates at 999999, the decimal display limit.
//  LINE_CLEAR_SCORE_EN undefined: no score port and no score logic; all other behaviour is identical.
// STRUCTURE
//  Shared global include holds:
//   - ROWS/COLS defaults and the FSM state encodings
//   - the score table constants and SCORE_MAX=999999
//  Sub-module line_clear_find_bottom: combinational priority encoder mask[0:ROWS-1] -> {found, row index}.
//  Row shift and counters stay in this module.
// TESTING
//  1. Empty board, start -> board_we/done at E+1, board_out=0, lines_cleared=0, total_lines=0.
//  2. Row 19 full, row 18 = 10'b1000000001, start -> commit at E+2.
//     Row 19 now holds 10'b1000000001, rows 0..18 are zero, lines_cleared=1, score=40.
//  3. Rows 16..19 full, row 15 = 10'b0000011111 -> commit at E+5.
//     Row 19 holds 10'b0000011111, lines_cleared=4, score=1200.
//  4. Non-adjacent full rows 12 and 19, distinct patterns in rows 11, 13 and 18 -> lines_cleared=2.
//     Rows 11/13/18 move to 13/14/19, order preserved, score=100.
//  5. start re-pulsed during CLEAR, and board_in changed mid-pass -> result matches the snapshot and
//     exactly one board_we occurs. rst_n=0 for one cycle mid-pass -> no board_we and all outputs at reset values.
//  6. Force total_lines=16'hFFFE, clear 3 rows -> 16'hFFFF.
//     Force score=999900, clear 4 rows -> 999999.

Source files
------------

// File: rtl/line_clear_engine_pkg.sv
// Shared constants for the line-clear engine: board geometry defaults,
// FSM state encodings, and the score table used when scoring is enabled.
package line_clear_engine_pkg;

    localparam int ROWS_DEF = 20;
    localparam int COLS_DEF = 10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam int SCORE_W = 20;
    localparam logic [SCORE_W-1:0] SCORE_1   = 20'd40;
    localparam logic [SCORE_W-1:0] SCORE_2   = 20'd100;
    localparam logic [SCORE_W-1:0] SCORE_3   = 20'd300;
    localparam logic [SCORE_W-1:0] SCORE_4   = 20'd1200;
    // Largest value the six-digit decimal display can show.
    localparam logic [SCORE_W-1:0] SCORE_MAX = 20'd999999;

    function automatic logic [SCORE_W-1:0] score_for(input logic [4:0] n);
        logic [SCORE_W-1:0] s;
        s = '0;
        if (n == 5'd1)
            s = SCORE_1;
        else if (n == 5'd2)
            s = SCORE_2;
        else if (n == 5'd3)
            s = SCORE_3;
        else if (n >= 5'd4)
            s = SCORE_4;
        return s;
    endfunction

endpackage

// File: rtl/line_clear_find_bottom.sv
// Priority encoder: reports whether any mask bit is set and the index of the
// highest-index set bit (the bottom-most full row). Ports: mask in; found, row out.
module line_clear_find_bottom #(
    parameter int ROWS  = 20,
    parameter int IDX_W = 5
) (
    input  logic [0:ROWS-1]  mask,
    output logic             found,
    output logic [IDX_W-1:0] row
);

    // Later iterations overwrite earlier ones, so the highest index wins.
    always_comb begin
        found = 1'b0;
        row   = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (mask[i]) begin
                found = 1'b1;
                row   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/line_clear_engine.sv
// Line-clear engine: snapshots the board and full-row flags on start, removes
// one full row per cycle (bottom-most first) and commits the compacted board.
// Ports: clk, rst_n (sync, active-low), start, board_in, full_lines in;
// board_out, board_we, done, busy, lines_cleared, total_lines out;
// score out only when LINE_CLEAR_SCORE_EN is defined.
module line_clear_engine
    import line_clear_engine_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [0:ROWS*COLS-1]   board_in,
    input  logic [0:ROWS-1]        full_lines,
    output logic [0:ROWS*COLS-1]   board_out,
    output logic                   board_we,
    output logic                   done,
    output logic                   busy,
    output logic [4:0]             lines_cleared,
    output logic [CNT_W-1:0]       total_lines
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [SCORE_W-1:0]     score
`endif
);

    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t state;
    state_t state_nx;

    logic [0:ROWS*COLS-1] brd;
    logic [0:ROWS*COLS-1] brd_sh;
    logic [0:ROWS-1]      mask;
    logic [0:ROWS-1]      mask_sh;
    logic [4:0]           k;
    logic                 found;
    logic [IDX_W-1:0]     bot;
    logic [CNT_W:0]       tot_sum;
    logic [CNT_W-1:0]     tot_nx;

    line_clear_find_bottom #(
        .ROWS  (ROWS),
        .IDX_W (IDX_W)
    ) u_find (
        .mask  (mask),
        .found (found),
        .row   (bot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start) state_nx = S_CLEAR;
            S_CLEAR:  if (!found) state_nx = S_COMMIT;
            S_COMMIT: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Drop row bot: rows 1..bot take the row above, row 0 fills with zeros.
    always_comb begin
        brd_sh         = brd;
        mask_sh        = mask;
        brd_sh[0 +: COLS] = '0;
        mask_sh[0]     = 1'b0;
        for (int i = 1; i < ROWS; i++) begin
            if (i <= int'(bot)) begin
                brd_sh[i*COLS +: COLS] = brd[(i-1)*COLS +: COLS];
                mask_sh[i]             = mask[i-1];
            end
        end
    end

    assign tot_sum = {1'b0, total_lines} + (CNT_W+1)'(k);
    assign tot_nx  = tot_sum[CNT_W] ? '1 : tot_sum[CNT_W-1:0];

`ifdef LINE_CLEAR_SCORE_EN
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_nx;

    assign score_sum = {1'b0, score} + {1'b0, score_for(k)};
    assign score_nx  = (score_sum > {1'b0, SCORE_MAX}) ?
                       SCORE_MAX : score_sum[SCORE_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n)
            score <= '0;
        else if (state == S_CLEAR && !found)
            score <= score_nx;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            brd           <= '0;
            mask          <= '0;
            k             <= '0;
            board_out     <= '0;
            board_we      <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            lines_cleared <= '0;
            total_lines   <= '0;
        end else begin
            board_we <= 1'b0;
            done     <= 1'b0;
            busy     <= (state_nx != S_IDLE);
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        brd  <= board_in;
                        mask <= full_lines;
                        k    <= '0;
                    end
                end
                S_CLEAR: begin
                    if (found) begin
                        brd  <= brd_sh;
                        mask <= mask_sh;
                        k    <= k + 5'd1;
                    end else begin
                        board_out     <= brd;
                        lines_cleared <= k;
                        total_lines   <= tot_nx;
                        board_we      <= 1'b1;
                        done          <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_engine.sv
// Self-checking bench for line_clear_engine: directed passes with a
// queue of expected commits built from an independent compaction model.
module tb_line_clear_engine;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int NB   = ROWS * COLS;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [0:NB-1]   board_in;
    logic [0:ROWS-1] full_lines;
    logic [0:NB-1]   board_out;
    logic            board_we;
    logic            done;
    logic            busy;
    logic [4:0]      lines_cleared;
    logic [15:0]     total_lines;
`ifdef LINE_CLEAR_SCORE_EN
    logic [19:0]     score;
    int              exp_score;
`endif

    int vectors = 0;
    int errors  = 0;
    int exp_total;

    typedef struct {
        logic [0:NB-1] brd;
        logic [4:0]    lines;
        logic [15:0]   total;
        logic [19:0]   score;
        int            lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    line_clear_engine dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .board_in      (board_in),
        .full_lines    (full_lines),
        .board_out     (board_out),
        .board_we      (board_we),
        .done          (done),
        .busy          (busy),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines)
`ifdef LINE_CLEAR_SCORE_EN
        ,
        .score         (score)
`endif
    );

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Keep non-full rows in bottom-up order, packed against the bottom.
    function automatic logic [0:NB-1] compact(input logic [0:NB-1] b,
                                              input logic [0:ROWS-1] fl);
        logic [0:NB-1] res;
        int dst;
        res = '0;
        dst = ROWS - 1;
        for (int src = ROWS - 1; src >= 0; src--) begin
            if (!fl[src]) begin
                res[dst*COLS +: COLS] = b[src*COLS +: COLS];
                dst--;
            end
        end
        return res;
    endfunction

    function automatic int score_of(input int n);
        int t[5] = '{0, 40, 100, 300, 1200};
        return t[(n > 4) ? 4 : n];
    endfunction

    task automatic do_pass(input string tag, input logic [0:NB-1] b,
                           input logic [0:ROWS-1] fl, input bit disturb);
        exp_t e;
        exp_t got;
        int   k;
        int   n;
        bit   seen;
        k = $countones(fl);
        exp_total = exp_total + k;
        if (exp_total > 65535) exp_total = 65535;
        e.brd   = compact(b, fl);
        e.lines = 5'(k);
        e.total = 16'(exp_total);
        e.score = '0;
`ifdef LINE_CLEAR_SCORE_EN
        exp_score = exp_score + score_of(k);
        if (exp_score > 999999) exp_score = 999999;
        e.score = 20'(exp_score);
`endif
        e.lat = k + 1;
        sb.push_back(e);
        @(negedge clk);
        board_in   = b;
        full_lines = fl;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        seen  = 1'b0;
        while (n <= ROWS + 4) begin
            if (board_we) begin
                seen = 1'b1;
                break;
            end
            if (disturb && n == 1) begin
                start      = 1'b1;
                board_in   = ~b;
                full_lines = '1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, ".we_seen"}, 256'(seen), 256'(1));
        got = sb.pop_front();
        check({tag, ".latency"}, 256'(n), 256'(got.lat));
        check({tag, ".board"}, 256'(board_out), 256'(got.brd));
        check({tag, ".lines"}, 256'(lines_cleared), 256'(got.lines));
        check({tag, ".total"}, 256'(total_lines), 256'(got.total));
        check({tag, ".done"}, 256'(done), 256'(1));
        check({tag, ".busy"}, 256'(busy), 256'(1));
`ifdef LINE_CLEAR_SCORE_EN
        check({tag, ".score"}, 256'(score), 256'(got.score));
`endif
        @(negedge clk);
        check({tag, ".we_pulse"}, 256'({board_we, done, busy}), 256'(0));
        if (disturb) begin
            seen = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (board_we) seen = 1'b1;
            end
            check({tag, ".single_we"}, 256'(seen), 256'(0));
        end
    endtask

    function automatic logic [0:NB-1] set_row(input logic [0:NB-1] b,
                                              input int r,
                                              input logic [0:COLS-1] v);
        logic [0:NB-1] t;
        t = b;
        t[r*COLS +: COLS] = v;
        return t;
    endfunction

    initial begin
        logic [0:NB-1]   b;
        logic [0:ROWS-1] fl;
        bit              seen;

        rst_n      = 1'b0;
        start      = 1'b0;
        board_in   = '0;
        full_lines = '0;
        exp_total  = 0;
`ifdef LINE_CLEAR_SCORE_EN
        exp_score  = 0;
`endif
        repeat (3) @(negedge clk);
        check("reset.ctrl", 256'({board_we, done, busy}), 256'(0));
        check("reset.board", 256'(board_out), 256'(0));
        check("reset.lines", 256'(lines_cleared), 256'(0));
        check("reset.total", 256'(total_lines), 256'(0));
        rst_n = 1'b1;

        do_pass("empty", '0, '0, 1'b0);

        b  = set_row('0, 19, '1);
        b  = set_row(b, 18, 10'b1000000001);
        fl = '0;
        fl[19] = 1'b1;
        do_pass("one_row", b, fl, 1'b0);

        b  = '0;
        fl = '0;
        for (int r = 16; r < 20; r++) begin
            b = set_row(b, r, '1);
            fl[r] = 1'b1;
        end
        b = set_row(b, 15, 10'b0000011111);
        do_pass("four_rows", b, fl, 1'b0);

        b  = set_row('0, 12, '1);
        b  = set_row(b, 19, '1);
        b  = set_row(b, 11, 10'b1010101010);
        b  = set_row(b, 13, 10'b0011001100);
        b  = set_row(b, 18, 10'b1110000111);
        fl = '0;
        fl[12] = 1'b1;
        fl[19] = 1'b1;
        do_pass("gap_rows", b, fl, 1'b0);

        do_pass("all_full", '1, '1, 1'b0);

        b  = '0;
        fl = '0;
        for (int r = 0; r < ROWS; r++)
            b = set_row(b, r, 10'($urandom_range(1, 1022)));
        for (int r = 14; r < 18; r++) begin
            b = set_row(b, r, '1);
            fl[r] = 1'b1;
        end
        do_pass("disturb", b, fl, 1'b1);

        for (int t = 0; t < 6; t++) begin
            b  = '0;
            fl = '0;
            for (int r = 0; r < ROWS; r++) begin
                if ($urandom_range(0, 3) == 0) begin
                    b = set_row(b, r, '1);
                    fl[r] = 1'b1;
                end else begin
                    b = set_row(b, r, 10'($urandom_range(0, 1022)));
                end
            end
            do_pass("random", b, fl, 1'b0);
        end

        b  = '0;
        fl = '0;
        for (int r = 10; r < 16; r++) begin
            b = set_row(b, r, '1);
            fl[r] = 1'b1;
        end
        @(negedge clk);
        board_in   = b;
        full_lines = fl;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.ctrl", 256'({board_we, done, busy}), 256'(0));
        check("midrst.board", 256'(board_out), 256'(0));
        check("midrst.lines", 256'(lines_cleared), 256'(0));
        check("midrst.total", 256'(total_lines), 256'(0));
`ifdef LINE_CLEAR_SCORE_EN
        check("midrst.score", 256'(score), 256'(0));
        exp_score = 0;
`endif
        exp_total = 0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (board_we) seen = 1'b1;
        end
        check("midrst.no_we", 256'(seen), 256'(0));

        @(negedge clk);
        force dut.total_lines = 16'hFFFE;
        #1;
        release dut.total_lines;
        exp_total = 65534;
        b  = '0;
        fl = '0;
        for (int r = 17; r < 20; r++) begin
            b = set_row(b, r, '1);
            fl[r] = 1'b1;
        end
        b = set_row(b, 16, 10'b0110011001);
        do_pass("total_sat", b, fl, 1'b0);

`ifdef LINE_CLEAR_SCORE_EN
        @(negedge clk);
        force dut.score = 20'd999900;
        #1;
        release dut.score;
        exp_score = 999900;
`endif
        b  = '0;
        fl = '0;
        for (int r = 16; r < 20; r++) begin
            b = set_row(b, r, '1);
            fl[r] = 1'b1;
        end
        do_pass("score_sat", b, fl, 1'b0);

        check("sb_empty", 256'(sb.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
